// File: rtl/hex_scan.sv
// hex_scan: multiplexed seven-segment display controller.
// Scans DIGITS common-anode digits with one shared hex decoder, blanks one
// cycle at every digit switch, optionally blanks leading zeros, and takes
// new display values through a one-entry pending buffer that is committed
// only at frame boundaries so a frame never mixes old and new digits.
module hex_scan #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value_in,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic                lz_en,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);

    localparam int CNT_W = $clog2(TICKS_PER_DIGIT);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic                pend_full_q, pend_full_d;

    logic                slot_end;
    logic                boundary;
    logic                accept;
    logic [3:0]          nib;
    logic                upper_zero;
    logic                blank;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end   = (cnt_q == CNT_LAST);
    assign boundary   = slot_end && (idx_q == IDX_LAST);
    assign accept     = load_valid && !pend_full_q;
    assign load_ready = !pend_full_q && !reset;
    assign frame_done = boundary && !reset;

    // Next-state: scan counters, frame-boundary commit and load acceptance.
    // Acceptance needs an empty buffer, so it never collides with a commit.
    always_comb begin
        cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = value_in;
            pend_full_d = 1'b1;
        end
    end

    // State registers; reset discards any pending value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Output decode: select current nibble, decide blanking, drive pins.
    always_comb begin
        nib        = 4'h0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib = disp_q[4*i +: 4];
            end
            if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = reset || (cnt_q == '0) || (lz_en && (idx_q != '0) && upper_zero);
        seg   = blank ? 7'b1111111 : hex7(nib);
        an    = blank ? '1 : ~(DIGITS'(1) << idx_q);
    end

endmodule

// File: tb/tb_hex_scan.sv
// Testbench for hex_scan: directed scenarios followed by random traffic,
// checked cycle by cycle against an arithmetic reference model through a
// scoreboard queue.
module tb_hex_scan;

    localparam int D  = 4;
    localparam int T  = 4;
    localparam int FR = D * T;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4*D-1:0] value_in = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          lz_en = 1'b0;
    logic [6:0]    seg;
    logic [D-1:0]  an;
    logic          frame_done;

    hex_scan #(.DIGITS(D), .TICKS_PER_DIGIT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lz_en      (lz_en),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   seg;
        logic [D-1:0] an;
        logic         rdy;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state: cycles since reset release and the buffer contents.
    int             m_t = 0;
    logic [4*D-1:0] m_disp = '0;
    logic [4*D-1:0] m_pend = '0;
    bit             m_full = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic exp_t model_out(input bit r, input bit lz);
        exp_t e;
        int   dig, ph;
        e.seg = 7'b1111111;
        e.an  = '1;
        e.rdy = 1'b0;
        e.fd  = 1'b0;
        if (!r) begin
            ph    = m_t % T;
            dig   = (m_t / T) % D;
            e.rdy = !m_full;
            e.fd  = ((m_t % FR) == FR - 1);
            if (ph != 0 && !(lz && dig > 0 && (m_disp >> (4 * dig)) == 0)) begin
                e.an  = ~(D'(1) << dig);
                e.seg = seg_tab[(m_disp >> (4 * dig)) & 4'hF];
            end
        end
        return e;
    endfunction

    function automatic void model_advance(input bit r, input bit v, input logic [4*D-1:0] val);
        bit acc;
        if (r) begin
            m_t = 0; m_disp = '0; m_pend = '0; m_full = 0;
        end else begin
            acc = v && !m_full;
            if ((m_t % FR) == FR - 1 && m_full) begin
                m_disp = m_pend;
                m_full = 0;
            end
            if (acc) begin
                m_pend = val;
                m_full = 1;
            end
            m_t++;
        end
    endfunction

    task automatic step(input bit r, input bit v, input logic [4*D-1:0] val, input bit lz);
        @(posedge clk);
        #1;
        reset      = r;
        load_valid = v;
        value_in   = val;
        lz_en      = lz;
        exp_q.push_back(model_out(r, lz));
        model_advance(r, v, val);
    endtask

    function automatic logic [4*D-1:0] rand_val();
        logic [4*D-1:0] x;
        for (int i = 0; i < D; i++) begin
            x[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        end
        return x;
    endfunction

    // Monitor: pop one expected entry per cycle and compare, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (seg !== e.seg) begin
                    n_mis++;
                    $display("FAIL seg t=%0t got %b want %b", $time, seg, e.seg);
                end
                if (an !== e.an) begin
                    n_mis++;
                    $display("FAIL an t=%0t got %b want %b", $time, an, e.an);
                end
                if (load_ready !== e.rdy) begin
                    n_mis++;
                    $display("FAIL load_ready t=%0t got %b want %b", $time, load_ready, e.rdy);
                end
                if (frame_done !== e.fd) begin
                    n_mis++;
                    $display("FAIL frame_done t=%0t got %b want %b", $time, frame_done, e.fd);
                end
            end
        end
    end

    // Driver: directed scenarios, then random traffic.
    initial begin
        int guard;
        // Reset held three cycles.
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0);
        // Load 12AF on the first cycle after release, watch two frames.
        step(0, 1, 16'h12AF, 0);
        for (int i = 0; i < 2 * FR + 4; i++) step(0, 0, '0, 0);
        // Leading-zero blanking with 0030, one frame on and one frame off.
        step(0, 1, 16'h0030, 0);
        for (int i = 0; i < 2 * FR; i++) step(0, 0, '0, 0);
        for (int i = 0; i < FR; i++) step(0, 0, '0, 1);
        for (int i = 0; i < FR; i++) step(0, 0, '0, 0);
        // Back-to-back loads with valid held.
        guard = 0;
        step(0, 1, 16'h1111, 0);
        while (m_full && m_pend == 16'h1111 && guard < 4 * FR) begin
            step(0, 1, 16'h2222, 0);
            guard++;
        end
        for (int i = 0; i < 3 * FR; i++) step(0, 0, '0, 0);
        // Load 5555 exactly on the boundary cycle with an empty buffer.
        guard = 0;
        while (!((m_t % FR) == FR - 1 && !m_full) && guard < 4 * FR) begin
            step(0, 0, '0, 0);
            guard++;
        end
        step(0, 1, 16'h5555, 0);
        for (int i = 0; i < 3 * FR; i++) step(0, 0, '0, 0);
        // Mid-frame reset (idx=2, cnt=2) with a pending value.
        step(0, 1, 16'h9876, 0);
        guard = 0;
        while ((m_t % FR) != 2 * T + 2 && guard < 4 * FR) begin
            step(0, 0, '0, 0);
            guard++;
        end
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        for (int i = 0; i < 3 * FR; i++) step(0, 0, '0, 0);
        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
                 rand_val(), 1'($urandom_range(0, 1)));
        end
        step(0, 0, '0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain left %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/hex_scan.md
# hex_scan

Multiplexed seven-segment display controller that time-shares one combinational `hex` decoder across `DIGITS` common-anode digits. Accepts a display value through a valid/ready handshake into a one-entry pending buffer and commits it to the displayed value only at frame boundaries, so a frame never shows a mix of old and new digits. Inserts one blank cycle at each digit switch to suppress ghosting, and optionally blanks leading zeros. Sits between user datapath values and the board's segment/anode pins.

## Interface
- `DIGITS`, 4, number of digits scanned; legal range 1..8.
- `TICKS_PER_DIGIT`, 50000, clock cycles per digit slot; must be ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `value_in` input 4*DIGITS: value to display; nibble i drives digit i, and digit 0 is the least significant digit.
- `load_valid` input 1: `value_in` is offered.
- `load_ready` output 1: pending buffer empty, so a load can be accepted.
- `lz_en` input 1: enable leading-zero blanking; sampled every cycle.
- `seg` output 7: segment pattern `{g,f,e,d,c,b,a}`, active-low.
- `an` output DIGITS: digit enables, active-low, at most one low at a time.
- `frame_done` output 1: one-cycle pulse on the last cycle of each frame.

## Operation
- State registers:
  - `cnt`: slot counter, 0..TICKS_PER_DIGIT-1, width $clog2(TICKS_PER_DIGIT).
  - `idx`: digit index, 0..DIGITS-1.
  - `disp`: displayed value, 4*DIGITS bits.
  - `pend`: pending value.
  - `pend_full`: pending buffer occupied.
- Scan: `cnt` increments every cycle. At `cnt`==TICKS_PER_DIGIT-1, `cnt` goes to 0 and `idx` goes to `idx`+1. `idx` wraps from DIGITS-1 to 0.
- Slot phases:
  - BLANK when `cnt`==0: `an`=all ones, `seg`=7'b1111111.
  - SHOW when `cnt`≥1: `an` has only bit `idx` low, and `seg`=hex(`disp` nibble `idx`).
- Decoder table (active-low), same as the team's `hex` block:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking: when `lz_en`=1 and `idx`>0 and every `disp` nibble at position ≥ `idx` is zero, the SHOW phase drives `an`=all ones and `seg`=7'b1111111. Digit 0 is never blanked.
- Handshake:
  - `load_ready` = !`pend_full` (low during reset).
  - A transfer happens when `load_valid` && `load_ready` at a rising edge. It sets `pend`=`value_in` and `pend_full`=1.
  - `value_in` is ignored when no transfer occurs.
- Frame boundary is the cycle where `cnt`==TICKS_PER_DIGIT-1 and `idx`==DIGITS-1.
  - `frame_done`=1 on that cycle.
  - If `pend_full`=1, then `disp`<=`pend` and `pend_full`<=0 at that edge.
- Simultaneous events:
  - Load accepted on the boundary cycle with the buffer empty: the value goes to `pend` only. `disp` is unchanged, and the value is committed at the next boundary.
  - Buffer full on the boundary cycle: the commit happens. `load_ready` is low that cycle, so no accept. `load_ready` rises the next cycle.
- Reset (any cycle, including mid-frame with pending full):
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pend_full`=0.
  - Any pending value is discarded.

## Timing
- Reset values while `reset`=1: `an`=all ones, `seg`=7'b1111111, `load_ready`=0, `frame_done`=0.
- First cycle after reset release: `cnt`=0 (BLANK) and `load_ready`=1.
- `seg`, `an` and `frame_done` are combinational from the registered state, with no added output latency.
- Slot length is TICKS_PER_DIGIT cycles, of which 1 is blank. Frame length is DIGITS*TICKS_PER_DIGIT cycles.
- Load-to-display latency: the committed value appears on the first SHOW cycle of digit 0 in the frame after the boundary, i.e. 2 cycles after the commit edge. The worst case from accept is 1 frame + 2 cycles.
- `load_ready` drops the cycle after an accept. It stays low until the cycle after the next boundary.

## Test plan
- Reset with DIGITS=4, TICKS=4, held 3 cycles -> `an`=1111, `seg`=1111111, `load_ready`=0 throughout. Cycle 0 after release is blank; cycles 1–3 give `an`=1110, `seg`=1000000; `frame_done` pulses at cycle 15.
- Load 16'h12AF on cycle 0 after reset -> accepted, with `load_ready`=0 from cycle 1 to cycle 15. `disp` commits at the end of cycle 15, and `load_ready`=1 at cycle 16. Next frame shows digit0 `seg`=0001110, digit1 0001000, digit2 0100100, digit3 1111001, with the corresponding single `an` bit low.
- `lz_en`=1 with committed value 16'h0030 -> digit3 and digit2 SHOW phases give `an`=1111, `seg`=1111111. Digit1 gives `seg`=0110000; digit0 gives `seg`=1000000. With `lz_en`=0, digit3 and digit2 show 1000000.
- Back-to-back loads 16'h1111 then 16'h2222 with `load_valid` held -> the second is stalled with `load_ready`=0 and accepted on the cycle after the first boundary. Frame 2 shows 1111 and frame 3 shows 2222; the value is never mixed within a frame.
- Load of 16'h5555 presented exactly on the boundary cycle with the buffer empty -> the following frame still shows the old value, and the frame after shows 5555.
- `reset` asserted mid-frame (idx=2, cnt=2) with `pend_full`=1 -> the next cycle gives `cnt`=0, `idx`=0, `disp`=0, `load_ready`=0 while held. After release the display shows 0000 and the pending value never appears.
